// File: rtl/axis_i2s_master.sv
// I2S clock-master transceiver.
// The block generates BCLK and LRCLK from aclk. It serialises AXI4-Stream
// stereo words to the DAC pin and deserialises ADC bits into AXI4-Stream
// stereo words. Slot timing follows standard I2S: the MSB appears one BCLK
// after LRCLK changes.
module axis_i2s_master #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int SLOT_WIDTH       = 32,
  parameter int BCLK_HALF        = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_dac_data,
  input  logic                        i2s_adc_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int D  = W / 2;
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int PW = $clog2(SLOT_WIDTH);
  localparam int CW = $clog2(BCLK_HALF);

  localparam logic [BW-1:0] B_LAST  = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] B_SLOT  = BW'(SLOT_WIDTH);
  localparam logic [CW-1:0] PS_LAST = CW'(BCLK_HALF - 1);
  localparam logic [PW-1:0] P_D     = PW'(D);

  logic [CW-1:0] presc;
  logic [BW-1:0] b;
  logic [W-1:0]  hold;
  logic [D-1:0]  shreg;
  logic [D-1:0]  left_cap;
  // Set by the first frame start after reset; blocks a partial word that
  // was only half-collected before that frame start.
  logic          armed;

  logic          tc, rise, fall, frame_start;
  logic [BW-1:0] b_new;
  logic          right_new, right_cur;
  logic [PW-1:0] p_new, p_cur;
  logic [D-1:0]  dac_half, dac_shift;
  logic          dac_next;
  logic [D-1:0]  sh_next;
  logic          adc_take, word_done;

  // Decode the BCLK events and the slot position before and after a fall event.
  always_comb begin
    tc          = (presc == PS_LAST);
    rise        = tc & ~i2s_bclk;
    fall        = tc & i2s_bclk;
    b_new       = (b == B_LAST) ? '0 : b + 1'b1;
    right_new   = (b_new >= B_SLOT);
    right_cur   = (b >= B_SLOT);
    p_new       = right_new ? PW'(b_new - B_SLOT) : PW'(b_new);
    p_cur       = right_cur ? PW'(b - B_SLOT) : PW'(b);
    frame_start = fall & (b_new == '0);
    dac_half    = right_new ? hold[D-1:0] : hold[W-1:D];
    dac_shift   = dac_half >> (P_D - p_new);
    dac_next    = ((p_new != '0) && (p_new <= P_D)) ? dac_shift[0] : 1'b0;
    sh_next     = {shreg[D-2:0], i2s_adc_data};
    adc_take    = rise & (p_cur != '0) & (p_cur <= P_D);
    word_done   = adc_take & (p_cur == P_D);
  end

  assign s_axis_tready = frame_start;

  // Clock generation, DAC serialisation, ADC deserialisation and the m_axis handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      presc         <= '0;
      i2s_bclk      <= 1'b0;
      i2s_lrclk     <= 1'b1;
      i2s_dac_data  <= 1'b0;
      b             <= B_LAST;
      hold          <= '0;
      shreg         <= '0;
      left_cap      <= '0;
      armed         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) i2s_bclk <= ~i2s_bclk;

      if (fall) begin
        b            <= b_new;
        i2s_lrclk    <= right_new;
        i2s_dac_data <= dac_next;
      end

      if (frame_start) begin
        hold  <= s_axis_tvalid ? s_axis_tdata : '0;
        armed <= 1'b1;
      end

      if (adc_take) shreg <= sh_next;
      if (word_done && !right_cur) left_cap <= sh_next;

      if (word_done && right_cur && armed) begin
        m_axis_tdata  <= {left_cap, sh_next};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_i2s_master.sv
// Bench for axis_i2s_master. It runs two instances:
//   dut_a: W=32, SLOT=32, HALF=2, driven through the directed sequences.
//   dut_b: W=32, SLOT=17, HALF=3, in free-running loopback.
// A cycle-count based model predicts every output on every cycle.
module tb_axis_i2s_master;
  localparam int D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn, bclk, lrclk, dac, adc, adc_drv, loop;
  logic [1:0]  stready, stvalid, mtready, mtvalid;
  logic [31:0] stdata [2];
  logic [31:0] mtdata [2];
  logic [31:0] pat_a;
  logic        bdone;

  assign adc = (loop & dac) | (~loop & adc_drv);

  axis_i2s_master #(.AXIS_TDATA_WIDTH(32), .SLOT_WIDTH(32), .BCLK_HALF(2)) dut_a (
    .aclk(clk), .aresetn(rstn[0]), .i2s_bclk(bclk[0]), .i2s_lrclk(lrclk[0]),
    .i2s_dac_data(dac[0]), .i2s_adc_data(adc[0]), .s_axis_tready(stready[0]),
    .s_axis_tdata(stdata[0]), .s_axis_tvalid(stvalid[0]), .m_axis_tready(mtready[0]),
    .m_axis_tdata(mtdata[0]), .m_axis_tvalid(mtvalid[0]));

  axis_i2s_master #(.AXIS_TDATA_WIDTH(32), .SLOT_WIDTH(17), .BCLK_HALF(3)) dut_b (
    .aclk(clk), .aresetn(rstn[1]), .i2s_bclk(bclk[1]), .i2s_lrclk(lrclk[1]),
    .i2s_dac_data(dac[1]), .i2s_adc_data(adc[1]), .s_axis_tready(stready[1]),
    .s_axis_tdata(stdata[1]), .s_axis_tvalid(stvalid[1]), .m_axis_tready(mtready[1]),
    .m_axis_tdata(mtdata[1]), .m_axis_tvalid(mtvalid[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic int half_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int slot_of(input int i);
    return (i == 0) ? 32 : 17;
  endfunction

  // F = number of fall events seen so far, F >= 1. The bit position after
  // fall F is (F-1) mod 2S. lr selects the channel and p the bit inside the slot.
  function automatic void pos(input int F, input int S, output int lr, output int p);
    int bb;
    bb = (F - 1) % (2 * S);
    lr = (bb >= S) ? 1 : 0;
    p  = bb % S;
  endfunction

  // ---------------- behavioural model ----------------
  // cnt counts the clock edges taken out of reset. Edge k is a BCLK event
  // when k is a multiple of H. Odd events are rises and even events are falls.
  int          cnt [2];
  bit          started [2];
  logic [31:0] fdat [2][64];
  logic [15:0] la [2];
  logic [15:0] ra [2];
  logic        ev [2];
  logic [31:0] ed [2];

  int   mh, ms, mk, mF, mlr, mp;
  logic nw;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        cnt[i] = 0; ev[i] = 1'b0; ed[i] = '0; started[i] = 1'b1;
      end else if (started[i]) begin
        mh = half_of(i); ms = slot_of(i); mk = cnt[i] + 1; nw = 1'b0;
        if (mk % (2 * mh) == mh) begin
          mF = mk / (2 * mh);
          if (mF >= 1) begin
            pos(mF, ms, mlr, mp);
            if (mp >= 1 && mp <= D) begin
              if (mlr == 1) ra[i][D-mp] = adc[i];
              else          la[i][D-mp] = adc[i];
            end
            if (mlr == 1 && mp == D) begin
              nw = 1'b1; ed[i] = {la[i], ra[i]};
            end
          end
        end
        if (nw) ev[i] = 1'b1;
        else if (ev[i] && mtready[i]) ev[i] = 1'b0;
        if (mk % (2 * mh) == 0) begin
          mF = mk / (2 * mh);
          if ((mF - 1) % (2 * ms) == 0)
            fdat[i][((mF - 1) / (2 * ms)) % 64] = stvalid[i] ? stdata[i] : 32'h0;
        end
        cnt[i] = mk;
      end
    end
  end

  // Compare every DUT output against the model on every cycle.
  int   ch, cs, cc, cF, clr, cp, cfr, ck;
  logic eb, elr, edac, etr;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (started[i]) begin
        ch = half_of(i); cs = slot_of(i); cc = cnt[i];
        eb = ((cc / ch) % 2) == 1;
        cF = cc / (2 * ch);
        if (cF == 0) begin
          elr = 1'b1; edac = 1'b0;
        end else begin
          pos(cF, cs, clr, cp);
          elr = (clr == 1);
          cfr = ((cF - 1) / (2 * cs)) % 64;
          edac = (cp >= 1 && cp <= D) ? fdat[i][cfr][(clr == 1 ? 0 : D) + D - cp] : 1'b0;
        end
        ck  = cc + 1;
        etr = (ck % (2 * ch) == 0) && (((ck / (2 * ch)) - 1) % (2 * cs) == 0);
        chk("bclk",    i, {31'b0, bclk[i]},    {31'b0, eb});
        chk("lrclk",   i, {31'b0, lrclk[i]},   {31'b0, elr});
        chk("dac",     i, {31'b0, dac[i]},     {31'b0, edac});
        chk("s_tready", i, {31'b0, stready[i]}, {31'b0, etr});
        chk("m_tvalid", i, {31'b0, mtvalid[i]}, {31'b0, ev[i]});
        chk("m_tdata", i, mtdata[i], ed[i]);
      end
    end
  end

  // Drive dut_a's ADC pin from a stereo pattern word at the slot position the model predicts.
  int dF, dlr, dp;
  initial begin
    adc_drv = 2'b00;
    forever begin
      @(negedge clk);
      dF = cnt[0] / 4;
      if (started[0] && dF >= 1) begin
        pos(dF, 32, dlr, dp);
        if (dp >= 1 && dp <= D) adc_drv[0] = pat_a[(dlr == 1 ? 0 : D) + D - dp];
        else                    adc_drv[0] = 1'b0;
      end else begin
        adc_drv[0] = 1'b0;
      end
    end
  end

  task automatic wait_tr(input int i, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!stready[i] && n < lim);
    chk("wait_tready", i, {31'b0, stready[i]}, 32'd1);
  endtask

  task automatic wait_mv(input int i, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!mtvalid[i] && n < lim);
    chk("wait_mvalid", i, {31'b0, mtvalid[i]}, 32'd1);
  endtask

  // Collect dut_a's DAC bit at each BCLK rise for one frame, and report the BCLK period.
  task automatic collect(output logic [63:0] bits, output int per);
    int   j, c, r0;
    logic pb;
    j = 0; c = 0; r0 = 0; per = 0; bits = '0; pb = bclk[0];
    while (j < 64 && c < 400) begin
      @(negedge clk); c++;
      if (bclk[0] && !pb) begin
        bits[j] = dac[0];
        if (j == 0) r0 = c;
        if (j == 1) per = c - r0;
        j++;
      end
      pb = bclk[0];
    end
    chk("collect_done", 0, j, 64);
  endtask

  // dut_b: SLOT=17, HALF=3, free-running loopback.
  initial begin : b_checks
    int c, n;
    bdone = 1'b0;
    wait (rstn[1] === 1'b1);
    c = 0;
    do begin
      @(negedge clk); c++;
    end while (!mtvalid[1] && c < 1000);
    chk("b_first_word_cycle", 1, c, 207);
    chk("b_first_word", 1, mtdata[1], 32'h5A5A_C3C3);
    wait_tr(1, 400, n);
    wait_tr(1, 400, n);
    chk("b_frame_len", 1, n, 204);
    wait_mv(1, 400, n);
    chk("b_second_word", 1, mtdata[1], 32'h5A5A_C3C3);
    bdone = 1'b1;
  end

  initial begin : main
    int n, c, per;
    logic [63:0] bits;
    logic [15:0] left16, right16;
    logic        extra, dacor, seen;
    logic [31:0] word;

    rstn = 2'b00; stvalid = 2'b11; mtready = 2'b11; loop = 2'b10; pat_a = '0;
    stdata[0] = 32'hA5A5_0F0F; stdata[1] = 32'h5A5A_C3C3;
    repeat (3) @(negedge clk);
    chk("rst_bclk", 0, {31'b0, bclk[0]}, 32'd0);
    chk("rst_lrclk", 0, {31'b0, lrclk[0]}, 32'd1);
    rstn = 2'b11;

    // DAC serialisation of 0xA5A5_0F0F.
    wait_tr(0, 600, n);
    chk("lr_at_tready", 0, {31'b0, lrclk[0]}, 32'd1);
    @(negedge clk);
    chk("lr_after_tready", 0, {31'b0, lrclk[0]}, 32'd0);
    collect(bits, per);
    chk("bclk_period", 0, per, 4);
    left16 = '0; right16 = '0; extra = 1'b0;
    for (int q = 1; q <= 16; q++) begin
      left16[16-q]  = bits[q];
      right16[16-q] = bits[32+q];
    end
    for (int q = 0; q < 32; q++) begin
      if (q == 0 || q > 16) extra = extra | bits[q] | bits[32+q];
    end
    chk("dac_left", 0, {16'b0, left16}, 32'h0000_A5A5);
    chk("dac_right", 0, {16'b0, right16}, 32'h0000_0F0F);
    chk("dac_pad", 0, {31'b0, extra}, 32'd0);
    wait_tr(0, 600, n);
    wait_tr(0, 600, n);
    chk("frame_len", 0, n, 256);

    // ADC loopback of 0x1234_ABCD. Each word is valid for exactly one cycle.
    loop[0] = 1'b1; stdata[0] = 32'h1234_ABCD;
    for (int r = 0; r < 2; r++) begin
      wait_mv(0, 300, n);
      chk("loop_word", 0, mtdata[0], 32'h1234_ABCD);
      @(negedge clk);
      chk("loop_valid_1cyc", 0, {31'b0, mtvalid[0]}, 32'd0);
    end

    // Underrun: one frame of silence, then data again.
    wait_tr(0, 600, n);
    stvalid[0] = 1'b0;
    @(negedge clk);
    stvalid[0] = 1'b1;
    dacor = 1'b0; seen = 1'b0; word = 32'hFFFF_FFFF;
    for (int k = 0; k < 250; k++) begin
      dacor = dacor | dac[0];
      if (mtvalid[0]) begin seen = 1'b1; word = mtdata[0]; end
      @(negedge clk);
    end
    chk("silence_dac", 0, {31'b0, dacor}, 32'd0);
    chk("silence_seen", 0, {31'b0, seen}, 32'd1);
    chk("silence_word", 0, word, 32'h0);
    wait_mv(0, 300, n);
    chk("after_silence", 0, mtdata[0], 32'h1234_ABCD);

    // Overrun with no consumer: tvalid stays high and the newest word wins.
    @(negedge clk);
    loop[0] = 1'b0; mtready[0] = 1'b0;
    wait_tr(0, 600, n);
    pat_a = 32'hFFFF_0001;
    wait_tr(0, 600, n);
    chk("ovr_first", 0, mtdata[0], 32'hFFFF_0001);
    wait_tr(0, 600, n);
    pat_a = 32'h8000_7FFF;
    wait_tr(0, 600, n);
    chk("ovr_valid", 0, {31'b0, mtvalid[0]}, 32'd1);
    chk("ovr_latest", 0, mtdata[0], 32'h8000_7FFF);
    mtready[0] = 1'b1;
    @(negedge clk);
    chk("ovr_cleared", 0, {31'b0, mtvalid[0]}, 32'd0);

    // Mid-frame reset at b=40, then a clean restart.
    loop[0] = 1'b1;
    wait_tr(0, 600, n);
    repeat (161) @(negedge clk);
    rstn[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    chk("mid_rst_bclk", 0, {31'b0, bclk[0]}, 32'd0);
    chk("mid_rst_lrclk", 0, {31'b0, lrclk[0]}, 32'd1);
    chk("mid_rst_dac", 0, {31'b0, dac[0]}, 32'd0);
    chk("mid_rst_valid", 0, {31'b0, mtvalid[0]}, 32'd0);
    c = 0;
    do begin
      @(negedge clk); c++;
    end while (!mtvalid[0] && c < 400);
    chk("first_word_cycle", 0, c, 198);
    chk("first_word_data", 0, mtdata[0], 32'h1234_ABCD);

    c = 0;
    while (!bdone && c < 2000) begin
      @(negedge clk); c++;
    end
    chk("b_done", 1, {31'b0, bdone}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
